// File: rtl/muldiv_seq.sv
// Iterative MIPS32 multiply/divide sequencer owning HI/LO.
// One shared add/subtract datapath; shift-add multiply, restoring divide.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic               is_div_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               b_zero_r;
    logic [WIDTH-1:0]   a_raw_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH-1:0]   mq_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               sgn_a_s;
    logic               sgn_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH+1:0]   addsub_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic s);
        logic [WIDTH-1:0] r;
        if (s) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic s);
        logic [2*WIDTH-1:0] r;
        if (s) begin
            r = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand sign flags and magnitudes at issue; unsigned ops pass raw values.
    always_comb begin
        sgn_a_s = ~op[0] & a[WIDTH-1];
        sgn_b_s = ~op[0] & b[WIDTH-1];
        mag_a_s = cond_neg(a, sgn_a_s);
        mag_b_s = cond_neg(b, sgn_b_s);
    end

    // Shared adder: trial subtract for divide, conditional add for multiply.
    always_comb begin
        addsub_s = {2'b00, rem_r};
        if (is_div_r) begin
            addsub_s = {1'b0, rem_r, mq_r[WIDTH-1]} - {2'b00, opnd_r};
        end else if (mq_r[0]) begin
            addsub_s = {2'b00, rem_r} + {2'b00, opnd_r};
        end else begin
            addsub_s = {2'b00, rem_r};
        end
    end

    // Final sign correction and divide-by-zero substitution.
    always_comb begin
        prod_s   = cond_neg2({rem_r, mq_r}, neg_q_r);
        fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_s[WIDTH-1:0];
        if (is_div_r) begin
            if (b_zero_r) begin
                fix_hi_s = a_raw_r;
                fix_lo_s = {WIDTH{1'b1}};
            end else begin
                fix_hi_s = cond_neg(rem_r, neg_r_r);
                fix_lo_s = cond_neg(mq_r, neg_q_r);
            end
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Sequencer state, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            b_zero_r <= 1'b0;
            a_raw_r  <= {WIDTH{1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            mq_r     <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (hi_we) hi_r <= wdata;
                    if (lo_we) lo_r <= wdata;
                    if (start && !flush) begin
                        state_r  <= ST_RUN;
                        busy_r   <= 1'b1;
                        cnt_r    <= {CW{1'b0}};
                        is_div_r <= op[1];
                        neg_q_r  <= sgn_a_s ^ sgn_b_s;
                        neg_r_r  <= sgn_a_s;
                        b_zero_r <= (b == {WIDTH{1'b0}});
                        a_raw_r  <= a;
                        opnd_r   <= op[1] ? mag_b_s : mag_a_s;
                        mq_r     <= op[1] ? mag_a_s : mag_b_s;
                        rem_r    <= {WIDTH{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        if (is_div_r) begin
                            // Restore on negative trial result; quotient bit is its complement.
                            if (!addsub_s[WIDTH+1]) begin
                                rem_r <= addsub_s[WIDTH-1:0];
                                mq_r  <= {mq_r[WIDTH-2:0], 1'b1};
                            end else begin
                                rem_r <= {rem_r[WIDTH-2:0], mq_r[WIDTH-1]};
                                mq_r  <= {mq_r[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            {rem_r, mq_r} <= {addsub_s[WIDTH:0], mq_r[WIDTH-1:1]};
                        end
                        if (cnt_r == LAST_ITER) state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        hi_r    <= fix_hi_s;
                        lo_r    <= fix_lo_s;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
